// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and write sequencer feeding the UART transmitter
module uart_tx_feeder #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int BUSY_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          Tx_WR,
  output logic [7:0]    Tx_DATA,
  input  logic          Tx_BUSY,
  output logic          tx_timeout
);

  localparam int CW = $clog2(BUSY_WAIT + 1);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(BUSY_WAIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            overflow_q, overflow_d;
  logic            tx_timeout_q, tx_timeout_d;
  logic            tx_wr_q, tx_wr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

  logic            pop;
  logic            push;
  logic            fifo_full;

  assign fifo_full = (level_q == LVL_FULL);

  // Next-state for FIFO storage, pointers, sticky flags and the issue sequencer
  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    tx_timeout_d = tx_timeout_q;
    tx_wr_d      = 1'b0;
    tx_data_d    = tx_data_q;
    wait_cnt_d   = wait_cnt_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then
    pop  = (state_q == IDLE) && enable && (level_q != '0) && !Tx_BUSY && !flush;
    push = wr_en && !flush && (!fifo_full || pop);

    if (wr_en && !flush && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
          tx_wr_d = 1'b1;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (Tx_BUSY) begin
          state_d = WAIT_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          // Transmitter never acknowledged: drop the byte and move on
          if (wait_cnt_q + 1'b1 == WAIT_LIMIT) begin
            tx_timeout_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!Tx_BUSY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush empties the queue and clears flags but leaves an in-flight byte alone
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      overflow_d   = 1'b0;
      tx_timeout_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
      tx_wr_q      <= 1'b0;
      tx_data_q    <= 8'h00;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      tx_timeout_q <= tx_timeout_d;
      tx_wr_q      <= tx_wr_d;
      tx_data_q    <= tx_data_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign full       = fifo_full;
  assign empty      = (level_q == '0);
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign tx_timeout = tx_timeout_q;
  assign Tx_WR      = tx_wr_q;
  assign Tx_DATA    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int BUSY_LEN = 20;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          Tx_WR;
  logic [7:0]    Tx_DATA;
  logic          Tx_BUSY;
  logic          tx_timeout;

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .BUSY_WAIT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .Tx_WR      (Tx_WR),
    .Tx_DATA    (Tx_DATA),
    .Tx_BUSY    (Tx_BUSY),
    .tx_timeout (tx_timeout)
  );

  typedef struct {
    logic [7:0] data;
    bit         accept;
    int         lvl;
    int         full;
    int         empty;
    int         ovf;
  } vec_t;

  vec_t       fill_tab [17];
  logic [7:0] sb_q [$];
  int         n_cmp;
  int         n_err;
  int         n_wr;
  int         cyc;
  int         wr_cyc;
  int         fall_cyc;
  bit         xmit_mode;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) sb_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int bound);
    int k;
    k = 0;
    while (n_wr < target && k < bound) begin
      tick();
      k++;
    end
    check("pulse_wait", n_wr, target);
  endtask

  task automatic wait_tx_wr(input int bound);
    int k;
    k = 0;
    while (!Tx_WR && k < bound) begin
      tick();
      k++;
    end
    check("tx_wr_seen", int'(Tx_WR), 1);
  endtask

  // Transmitter model: busy rises the cycle after Tx_WR and lasts BUSY_LEN cycles
  initial begin
    int  busy_left;
    bit  start_pend;
    busy_left  = 0;
    start_pend = 1'b0;
    Tx_BUSY    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) Tx_BUSY = 1'b0;
      end
      if (start_pend) begin
        Tx_BUSY    = 1'b1;
        busy_left  = BUSY_LEN;
        start_pend = 1'b0;
      end
      if (Tx_WR && xmit_mode) start_pend = 1'b1;
    end
  end

  // Output monitor: every Tx_WR pulse is checked against the scoreboard
  initial begin
    bit wr_prev;
    bit busy_prev;
    wr_prev   = 1'b0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (Tx_WR) begin
        n_wr++;
        wr_cyc = cyc;
        check("tx_wr_single", int'(wr_prev), 0);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_wr_unexpected: got byte %0h expected no pulse", Tx_DATA);
        end else begin
          check("tx_data", int'(Tx_DATA), int'(sb_q.pop_front()));
        end
      end
      if (busy_prev && !Tx_BUSY) fall_cyc = cyc;
      wr_prev   = Tx_WR;
      busy_prev = Tx_BUSY;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int k;

    n_cmp = 0; n_err = 0; n_wr = 0; cyc = 0; wr_cyc = 0; fall_cyc = 0;
    xmit_mode = 1'b1;
    reset = 1'b0; enable = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;

    for (int i = 0; i < 17; i++) begin
      fill_tab[i].data   = 8'(i);
      fill_tab[i].accept = (i < DEPTH);
      fill_tab[i].lvl    = (i < DEPTH) ? i + 1 : DEPTH;
      fill_tab[i].full   = (i >= DEPTH - 1) ? 1 : 0;
      fill_tab[i].empty  = 0;
      fill_tab[i].ovf    = (i == DEPTH) ? 1 : 0;
    end

    // Reset state
    #3;
    check("rst_level", int'(level), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_timeout", int'(tx_timeout), 0);
    check("rst_tx_wr", int'(Tx_WR), 0);
    check("rst_tx_data", int'(Tx_DATA), 0);
    tick();
    reset = 1'b1;
    tick();

    // Two bytes through a transmitter that stays busy for 20 cycles
    enable = 1'b1;
    n0 = n_wr;
    push_byte(8'hA5, 1'b1);
    push_byte(8'h3C, 1'b1);
    wait_pulses(n0 + 2, 200);
    check("wr_spacing_ok", int'(wr_cyc - fall_cyc >= 2), 1);
    settle(30);
    check("t1_empty", int'(empty), 1);

    // Fill with transmission disabled; 17th byte overflows
    enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push_byte(fill_tab[i].data, fill_tab[i].accept);
      check($sformatf("fill_level_%0d", i), int'(level), fill_tab[i].lvl);
      check($sformatf("fill_full_%0d", i), int'(full), fill_tab[i].full);
      check($sformatf("fill_empty_%0d", i), int'(empty), fill_tab[i].empty);
      check($sformatf("fill_ovf_%0d", i), int'(overflow), fill_tab[i].ovf);
    end

    // Flush clears FIFO and overflow, then refill
    flush = 1'b1;
    sb_q.delete();
    tick();
    flush = 1'b0;
    check("flush_level", int'(level), 0);
    check("flush_ovf", int'(overflow), 0);
    check("flush_empty", int'(empty), 1);
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b1);
    check("refill_full", int'(full), 1);
    check("refill_level", int'(level), DEPTH);

    // Push on the pop cycle of a full FIFO is accepted
    n0 = n_wr;
    enable  = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    sb_q.push_back(8'hEE);
    tick();
    wr_en = 1'b0;
    check("pushpop_level", int'(level), DEPTH);
    check("pushpop_ovf", int'(overflow), 0);
    check("pushpop_full", int'(full), 1);
    wait_pulses(n0 + 17, 17 * 30);
    settle(30);
    check("drain_empty", int'(empty), 1);
    check("drain_sb", sb_q.size(), 0);

    // Transmitter never goes busy: timeout after 8 wait cycles
    xmit_mode = 1'b0;
    n0 = n_wr;
    push_byte(8'h77, 1'b1);
    push_byte(8'h78, 1'b1);
    wait_tx_wr(20);
    k = 0;
    while (!tx_timeout && k < 30) begin
      tick();
      k++;
    end
    check("timeout_latency", k, 9);
    wait_pulses(n0 + 2, 40);
    settle(20);
    check("timeout_sticky", int'(tx_timeout), 1);
    check("timeout_empty", int'(empty), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("timeout_cleared", int'(tx_timeout), 0);
    xmit_mode = 1'b1;

    // Flush with simultaneous write during WAIT_DONE of the first byte
    n0 = n_wr;
    for (int i = 0; i < 5; i++) push_byte(8'h51 + 8'(i), 1'b1);
    k = 0;
    while (!Tx_BUSY && k < 40) begin
      tick();
      k++;
    end
    check("busy_seen", int'(Tx_BUSY), 1);
    tick();
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    sb_q.delete();
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("fl_level", int'(level), 0);
    check("fl_empty", int'(empty), 1);
    check("fl_ovf", int'(overflow), 0);
    settle(80);
    check("fl_pulses", n_wr - n0, 1);

    // Asynchronous reset in the ISSUE cycle
    push_byte(8'h5A, 1'b1);
    push_byte(8'h6B, 1'b1);
    wait_tx_wr(20);
    reset = 1'b0;
    #1;
    check("arst_tx_wr", int'(Tx_WR), 0);
    check("arst_tx_data", int'(Tx_DATA), 0);
    check("arst_level", int'(level), 0);
    check("arst_empty", int'(empty), 1);
    sb_q.delete();
    tick();
    reset = 1'b1;
    settle(30);
    n0 = n_wr;
    push_byte(8'hC3, 1'b1);
    wait_pulses(n0 + 1, 40);
    settle(30);
    check("post_rst_empty", int'(empty), 1);
    check("final_sb", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
